// File: rtl/dadda_pkg.sv
// Shared constants for the 16x16 Dadda multiplier: sizes, stage height targets,
// latency (2 when DADDA_IN_REG_EN is defined, else 1) and the tree layout tables.
package dadda_pkg;

    localparam int WIDTH   = 16;
    localparam int PROD_W  = 2 * WIDTH;
    localparam int N_STAGE = 6;
    localparam int DADDA_D [N_STAGE] = '{32'sd13, 32'sd9, 32'sd6, 32'sd4, 32'sd3, 32'sd2};

`ifdef DADDA_IN_REG_EN
    localparam int LATENCY = 2;
`else
    localparam int LATENCY = 1;
`endif

    localparam int TAB_HEIGHT = 0;
    localparam int TAB_FA     = 1;
    localparam int TAB_HA     = 2;
    localparam int TAB_OFF    = 3;

    // [stage][column] -> height, adder counts used leaving that stage, or bit offset
    typedef logic [N_STAGE:0][PROD_W-1:0][11:0] tab_t;

    // Walks the Dadda reduction column by column; carries produced in column c-1
    // count against column c's budget in the same stage.
    function automatic tab_t dadda_tab(input int sel);
        tab_t t;
        int   h  [PROD_W];
        int   nh [PROD_W];
        int   cin;
        int   ex;
        int   nfa;
        int   nha;
        int   off;
        t = '0;
        for (int c = 0; c < PROD_W; c++) begin
            h[c] = (c < WIDTH) ? c + 1 : ((c < PROD_W - 1) ? PROD_W - 1 - c : 0);
        end
        for (int s = 0; s <= N_STAGE; s++) begin
            cin = 0;
            off = 0;
            for (int c = 0; c < PROD_W; c++) begin
                nfa = 0;
                nha = 0;
                if (s < N_STAGE) begin
                    ex = h[c] + cin - DADDA_D[s];
                    if (ex > 0) begin
                        nfa = ex / 2;
                        nha = ex % 2;
                    end
                end
                case (sel)
                    TAB_HEIGHT: t[s][c] = 12'(h[c]);
                    TAB_FA:     t[s][c] = 12'(nfa);
                    TAB_HA:     t[s][c] = 12'(nha);
                    default:    t[s][c] = 12'(off);
                endcase
                off   = off + h[c];
                nh[c] = h[c] - 2 * nfa - nha + cin;
                cin   = nfa + nha;
            end
            h = nh;
        end
        return t;
    endfunction

endpackage

// File: rtl/dadda_if.sv
// Bundled multiplier port set shared by the core and its test environment.
interface dadda_if
    import dadda_pkg::*;
(
    input logic clk
);
    logic              rst;
    logic [WIDTH-1:0]  in1;
    logic [WIDTH-1:0]  in2;
    logic [PROD_W-1:0] out;
    logic              overflow;

    modport dut (input clk, rst, in1, in2, output out, overflow);
    modport tb  (input clk, out, overflow, output rst, in1, in2);
endinterface

// File: rtl/dadda_fa.sv
// One-bit full adder; tie cin to 0 to use it as a half adder.
module dadda_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/dadda_16_core.sv
// 16x16 unsigned Dadda multiplier with a registered 33-bit result.
// Define DADDA_IN_REG_EN to register the operands as well (latency 2 instead of 1).
module dadda_16_core
    import dadda_pkg::*;
#(
    parameter int WIDTH  = dadda_pkg::WIDTH,
    parameter int PROD_W = dadda_pkg::PROD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in1,
    input  logic [WIDTH-1:0]  in2,
    output logic [PROD_W-1:0] out,
    output logic              overflow
);

    localparam tab_t HT  = dadda_tab(TAB_HEIGHT);
    localparam tab_t FA  = dadda_tab(TAB_FA);
    localparam tab_t HA  = dadda_tab(TAB_HA);
    localparam tab_t OFF = dadda_tab(TAB_OFF);

    logic [WIDTH-1:0]  a_s;
    logic [WIDTH-1:0]  b_s;
    logic [PROD_W-1:0] row_a_s;
    logic [PROD_W-1:0] row_b_s;
    logic [PROD_W:0]   sum_s;

`ifdef DADDA_IN_REG_EN
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    // Operand capture ahead of the tree
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
        end else begin
            a_r <= in1;
            b_r <= in2;
        end
    end

    assign a_s = a_r;
    assign b_s = b_r;
`else
    assign a_s = in1;
    assign b_s = in2;
`endif

    // Each stage packs its columns back to back: sums, pass-throughs, then carries in.
    for (genvar s = 0; s <= N_STAGE; s++) begin : g_st
        localparam int SW = int'(OFF[s][PROD_W-1]) + int'(HT[s][PROD_W-1]);
        logic [SW-1:0] bits_s;

        if (s == 0) begin : g_pp
            for (genvar i = 0; i < WIDTH; i++) begin : g_i
                for (genvar j = 0; j < WIDTH; j++) begin : g_j
                    localparam int C = i + j;
                    localparam int K = i - ((C > WIDTH - 1) ? C - (WIDTH - 1) : 0);
                    assign bits_s[int'(OFF[0][C]) + K] = a_s[i] & b_s[j];
                end
            end
        end else begin : g_red
            for (genvar c = 0; c < PROD_W; c++) begin : g_col
                localparam int P   = s - 1;
                localparam int H   = int'(HT[P][c]);
                localparam int NF  = int'(FA[P][c]);
                localparam int NH  = int'(HA[P][c]);
                localparam int NP  = H - 3 * NF - 2 * NH;
                localparam int SRC = int'(OFF[P][c]);
                localparam int DST = int'(OFF[s][c]);
                localparam int CN  = (c < PROD_W - 1) ? c + 1 : c;
                localparam int CDST = int'(OFF[s][CN]) + int'(HT[P][CN])
                                    - 2 * int'(FA[P][CN]) - int'(HA[P][CN]);

                for (genvar f = 0; f < NF; f++) begin : g_fa
                    dadda_fa u_fa (
                        .a    (g_st[P].bits_s[SRC + 3 * f]),
                        .b    (g_st[P].bits_s[SRC + 3 * f + 1]),
                        .cin  (g_st[P].bits_s[SRC + 3 * f + 2]),
                        .sum  (bits_s[DST + f]),
                        .cout (bits_s[CDST + f])
                    );
                end

                for (genvar g = 0; g < NH; g++) begin : g_ha
                    dadda_fa u_ha (
                        .a    (g_st[P].bits_s[SRC + 3 * NF + 2 * g]),
                        .b    (g_st[P].bits_s[SRC + 3 * NF + 2 * g + 1]),
                        .cin  (1'b0),
                        .sum  (bits_s[DST + NF + g]),
                        .cout (bits_s[CDST + NF + g])
                    );
                end

                for (genvar q = 0; q < NP; q++) begin : g_pass
                    assign bits_s[DST + NF + NH + q] = g_st[P].bits_s[SRC + 3 * NF + 2 * NH + q];
                end
            end
        end
    end

    // Final stage has at most two bits per column; empty slots read as zero.
    for (genvar c = 0; c < PROD_W; c++) begin : g_rows
        localparam int H6 = int'(HT[N_STAGE][c]);
        localparam int O6 = int'(OFF[N_STAGE][c]);
        if (H6 >= 1) begin : g_a
            assign row_a_s[c] = g_st[N_STAGE].bits_s[O6];
        end else begin : g_a0
            assign row_a_s[c] = 1'b0;
        end
        if (H6 >= 2) begin : g_b
            assign row_b_s[c] = g_st[N_STAGE].bits_s[O6 + 1];
        end else begin : g_b0
            assign row_b_s[c] = 1'b0;
        end
    end

    assign sum_s = {1'b0, row_a_s} + {1'b0, row_b_s};

    // Result register; the adder carry-out lands in overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            out      <= '0;
            overflow <= 1'b0;
        end else begin
            out      <= sum_s[PROD_W-1:0];
            overflow <= sum_s[PROD_W];
        end
    end

endmodule

// File: tb/tb_dadda_16_core.sv
// Directed and random product checks for dadda_16_core, latency taken from dadda_pkg.
module tb_dadda_16_core;
    import dadda_pkg::*;

    logic clk;
    int   n_vec;
    int   n_err;

    logic [15:0] va [$];
    logic [15:0] vb [$];
    logic [32:0] ve [$];
    string       vt [$];

    dadda_if mif (.clk(clk));

    dadda_16_core dut (
        .clk      (clk),
        .rst      (mif.rst),
        .in1      (mif.in1),
        .in2      (mif.in2),
        .out      (mif.out),
        .overflow (mif.overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic add_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [32:0] e);
        va.push_back(a);
        vb.push_back(b);
        ve.push_back(e);
        vt.push_back(tag);
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic r);
        @(negedge clk);
        mif.in1 = a;
        mif.in2 = b;
        mif.rst = r;
    endtask

    // One operand pair per cycle; each result is checked exactly LATENCY edges later.
    task automatic run_stream();
        int due [$];
        int n;
        int idx;
        n = va.size();
        for (int k = 0; k < n + LATENCY - 1; k++) begin
            @(negedge clk);
            mif.rst = 1'b0;
            if (k < n) begin
                mif.in1 = va[k];
                mif.in2 = vb[k];
                due.push_back(k);
            end
            @(posedge clk);
            #1;
            if (k >= LATENCY - 1) begin
                idx = due.pop_front();
                check_vec(vt[idx], {mif.overflow, mif.out}, ve[idx]);
            end
        end
        va.delete();
        vb.delete();
        ve.delete();
        vt.delete();
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        n_vec   = 0;
        n_err   = 0;
        mif.rst = 1'b1;
        mif.in1 = 16'hFFFF;
        mif.in2 = 16'hFFFF;

        drive(16'hFFFF, 16'hFFFF, 1'b1);
        drive(16'hFFFF, 16'hFFFF, 1'b1);
        @(posedge clk);
        #1;
        check_vec("reset", {mif.overflow, mif.out}, 33'h0);

        add_vec("fff_sq",   16'h0FFF, 16'h0FFF, 33'h0_00FF_E001);
        add_vec("ffff_sq",  16'hFFFF, 16'hFFFF, 33'h0_FFFE_0001);
        add_vec("zero_op",  16'h0000, 16'hBEEF, 33'h0_0000_0000);
        add_vec("one_op",   16'h0001, 16'hBEEF, 33'h0_0000_BEEF);
        add_vec("op_one",   16'hBEEF, 16'h0001, 33'h0_0000_BEEF);
        add_vec("b2b_1",    16'h1234, 16'h5678, 33'h0_0626_0060);
        add_vec("b2b_2",    16'h8000, 16'h0002, 33'h0_0001_0000);
        add_vec("alt_bits", 16'hAAAA, 16'h5555, 33'h0_38E3_1C72);
        add_vec("msb_sq",   16'h8000, 16'h8000, 33'h0_4000_0000);
        add_vec("ffff_one", 16'hFFFF, 16'h0001, 33'h0_0000_FFFF);
        run_stream();

        drive(16'h1234, 16'h5678, 1'b0);
        drive(16'h0FFF, 16'h0FFF, 1'b0);
        drive(16'hFFFF, 16'hFFFF, 1'b1);
        @(posedge clk);
        #1;
        check_vec("rst_mid", {mif.overflow, mif.out}, 33'h0);

        add_vec("post_rst_1", 16'h0003, 16'h0005, 33'h0_0000_000F);
        add_vec("post_rst_2", 16'h0100, 16'h0100, 33'h0_0001_0000);
        run_stream();

        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            add_vec("rand", ra, rb, {17'd0, ra} * {17'd0, rb});
        end
        run_stream();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dadda_16_core.md
DADDA_16_CORE -- requirements
Module: dadda_16

Interface
REQ-001 Parameter WIDTH, default 16, operand width; only 16 is supported.
REQ-002 Parameter PROD_W, default 32 (2*WIDTH), product width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in1  input  16  unsigned multiplicand.
REQ-007 in2  input  16  unsigned multiplier.
REQ-008 out  output  32  unsigned product in1*in2.
REQ-009 overflow  output  1  carry-out of the final carry-propagate adder (bit 32 of the sum).
REQ-010 The ports SHALL be reachable as a bundled multiplier interface (modport "dut side"), with in1/in2 driven by the bench and out/overflow driven by the block.

Function
REQ-011 The block SHALL compute the exact unsigned product, with {overflow,out} == in1*in2 zero-extended to 33 bits for every operand pair.
REQ-012 overflow SHALL be 0 for all legal inputs, including 0xFFFF*0xFFFF giving 0xFFFE0001.
REQ-013 Partial products SHALL be the 256 AND terms in1[i]&in2[j], with weight i+j, in columns 0..30.
REQ-014 Reduction SHALL follow the Dadda height sequence 13, 9, 6, 4, 3, 2 (six stages); each stage uses the minimum number of full and half adders needed to bring every column to at most the target height.
REQ-015 After reduction, two 32-bit rows SHALL feed one 32-bit ripple or prefix adder; its carry-out drives overflow.
REQ-016 The multiplier datapath SHALL be combinational; out and overflow SHALL be registered once on clk (latency 1 cycle when the config macro is off).
REQ-017 New operands MAY be presented every cycle; throughput is one product per cycle; there is no handshake.
REQ-018 Operands of 0 SHALL give out=0 and overflow=0; operands of 1 SHALL pass the other operand through unchanged.

Reset
REQ-019 While rst=1 at a rising clk edge, out SHALL become 0 and overflow SHALL become 0 (and input registers SHALL clear if present).
REQ-020 Reset asserted mid-stream SHALL discard in-flight products; the first valid output SHALL appear at the full latency after rst deasserts.

Configuration
REQ-021 Macro DADDA_IN_REG_EN: when defined, in1/in2 SHALL be registered before the reduction tree, giving a total latency of 2 cycles.
REQ-022 When DADDA_IN_REG_EN is not defined, there SHALL be no input registers and the latency SHALL be 1 cycle; the arithmetic result is identical in both cases.

Structure
REQ-023 Package dadda_pkg SHALL hold WIDTH, PROD_W, the Dadda height constant array {13,9,6,4,3,2}, and the latency constant.
REQ-024 Full-adder and half-adder cells SHALL be a single sub-module dadda_fa with a half-adder mode (cin tied to 0), instantiated throughout the tree.
REQ-025 The multiplier interface definition SHALL live beside the package and be shared with the bench.

Verification
REQ-026 in1=0x0FFF, in2=0x0FFF -> out=0x00FFE001, overflow=0 after the latency.
REQ-027 in1=0xFFFF, in2=0xFFFF -> out=0xFFFE0001, overflow=0.
REQ-028 in1=0x0000, in2=0xBEEF -> out=0; in1=0x0001, in2=0xBEEF -> out=0x0000BEEF.
REQ-029 Back-to-back pairs (0x1234*0x5678, then 0x8000*0x0002) on consecutive cycles -> 0x06260060, then 0x00010000, each exactly one latency apart.
REQ-030 Assert rst for one cycle while operands are streaming -> out=0 and overflow=0 on the next edge, then correct products resume after the latency.
REQ-031 Run 10000 random operand pairs against a golden model, in both macro settings -> {overflow,out} == in1*in2 every cycle.
